// File: rtl/zap_wb_pkg.sv
`default_nettype none
//============================================================================
// Module      : zap_wb_pkg
// Description : Shared Wishbone definitions for the ZAP bus responders:
//               cycle-type encodings, responder state type and a small helper.
// Revision    : 1.0 - initial release
//============================================================================
package zap_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'd0;
    localparam logic [2:0] CTI_BURST   = 3'd2;
    localparam logic [2:0] CTI_EOB     = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        XFER  = 2'd2,
        BURST = 2'd3
    } wb_slv_state_t;

    // True when the master signals that more beats follow this one.
    function automatic logic cti_continues(input logic [2:0] cti);
        return cti != CTI_EOB;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zap_wb_slave_ram.sv
`default_nettype none
//============================================================================
// Module      : zap_wb_slave_ram
// Description : Single-port synchronous RAM, DEPTH_WORDS x 32, byte-lane write
//               enables and a registered read that returns zero when no read
//               is requested (so it can drive the bus data output directly).
// Revision    : 1.0 - initial release
//============================================================================
module zap_wb_slave_ram #(
    parameter int DEPTH_WORDS = 4096,
    parameter int ADR_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             i_clk,
    input  logic [ADR_W-1:0] i_adr,
    input  logic [3:0]       i_we,
    input  logic [31:0]      i_dat,
    input  logic             i_re,
    output logic [31:0]      o_dat
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdat;

    // Byte-lane write: only enabled lanes are updated.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_adr][8*b +: 8] <= i_dat[8*b +: 8];
            end
        end
    end

    // One-cycle registered read; output is forced to zero when not reading.
    always_ff @(posedge i_clk) begin
        r_rdat <= i_re ? r_mem[i_adr] : 32'd0;
    end

    assign o_dat = r_rdat;

endmodule
`default_nettype wire

// File: rtl/zap_wb_burst_slave.sv
`default_nettype none
//============================================================================
// Module      : zap_wb_burst_slave
// Description : Wishbone B3 responder with registered feedback. Serves
//               classic and incrementing-burst cycles from on-chip RAM, with
//               programmable wait states before the first ack and an
//               out-of-range error response.
// Revision    : 1.0 - initial release
//============================================================================
module zap_wb_burst_slave
    import zap_wb_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_wen,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [2:0]  i_wb_cti,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    localparam int         c_ram_aw = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_wait   = 4'(WAIT_STATES);
    localparam logic [30:0] c_depth = 31'(DEPTH_WORDS);

    wb_slv_state_t r_state, w_state_nxt;
    logic [29:0]   r_iadr, w_iadr_nxt;
    logic          r_wen, w_wen_nxt;
    logic [2:0]    r_cti, w_cti_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic          r_ack, r_err;

    logic                w_req, w_beat, w_beat_nxt, w_oor_nxt;
    logic                w_wr, w_rd;
    logic [c_ram_aw-1:0] w_ram_adr;
    logic [3:0]          w_ram_we;
    logic                w_unused;

    assign w_req    = i_wb_cyc & i_wb_stb;
    assign w_beat   = (r_state == XFER) || (r_state == BURST);
    // Byte offset bits carry no information for a word-wide responder.
    assign w_unused = &{1'b0, i_wb_adr[1:0]};

    // Next-state decode; computed one cycle ahead so the RAM read lines up with ack.
    always_comb begin
        w_state_nxt = r_state;
        w_iadr_nxt  = r_iadr;
        w_wen_nxt   = r_wen;
        w_cti_nxt   = r_cti;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_iadr_nxt  = i_wb_adr[31:2];
                    w_wen_nxt   = i_wb_wen;
                    w_cti_nxt   = i_wb_cti;
                    w_cnt_nxt   = c_wait;
                    w_state_nxt = (WAIT_STATES > 0) ? WAIT : XFER;
                end
            end
            WAIT: begin
                if (!i_wb_cyc) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = XFER;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            XFER, BURST: begin
                // An error beat or a dropped cycle/strobe always terminates.
                if (!r_err && w_req && (r_cti == CTI_BURST) && cti_continues(i_wb_cti)) begin
                    w_state_nxt = BURST;
                    w_iadr_nxt  = r_iadr + 30'd1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (i_reset) begin
            w_state_nxt = IDLE;
        end
    end

    assign w_beat_nxt = (w_state_nxt == XFER) || (w_state_nxt == BURST);
    // Full 30-bit address compared, so addresses aliasing into the RAM still error.
    assign w_oor_nxt  = {1'b0, w_iadr_nxt} >= c_depth;
    assign w_rd       = w_beat_nxt & ~w_oor_nxt & ~w_wen_nxt;
    assign w_wr       = w_beat & r_ack & r_wen & w_req & ~i_reset;
    assign w_ram_we   = {4{w_wr}} & i_wb_sel;
    // Write beats and look-ahead reads never coincide, so one port suffices.
    assign w_ram_adr  = w_wr ? r_iadr[c_ram_aw-1:0] : w_iadr_nxt[c_ram_aw-1:0];

    // FSM state, latched cycle attributes and registered ack/err.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_iadr  <= 30'd0;
            r_wen   <= 1'b0;
            r_cti   <= CTI_CLASSIC;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_iadr  <= w_iadr_nxt;
            r_wen   <= w_wen_nxt;
            r_cti   <= w_cti_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_beat_nxt & ~w_oor_nxt;
            r_err   <= w_beat_nxt & w_oor_nxt;
        end
    end

    zap_wb_slave_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADR_W       (c_ram_aw)
    ) u_ram (
        .i_clk (i_clk),
        .i_adr (w_ram_adr),
        .i_we  (w_ram_we),
        .i_dat (i_wb_dat),
        .i_re  (w_rd),
        .o_dat (o_wb_dat)
    );

    assign o_wb_ack = r_ack;
    assign o_wb_err = r_err;

endmodule
`default_nettype wire
